// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the execute stage.
// Generates per-stage stall/flush controls and the fetch redirect. It covers three cases:
//   - load-use hazards between decode and exec;
//   - taken branches/jumps from exec, turned into a one-cycle redirect;
//   - trap entry: drain older instructions, then jump to mtvec.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   id_valid, id_rs1/2, id_uses_rs1/2 decode-stage operand info
//   ex_rd, ex_reg_write, ex_mem_read exec output register destination info
//   ex_branch_*/ex_jump_*            resolved control flow from exec
//   ex_trap, ex_trap_cause, ex_pc    trap request from exec
//   mtvec                            trap vector base
//   mem_busy                         data memory not ready
//   stall_if/id/ex, flush_id/ex      pipeline controls (combinational)
//   redirect_valid, redirect_pc      fetch redirect
//   trap_commit, trap_cause/epc      trap taken pulse and latched trap info
module pipe_hazard_ctrl #(
    parameter int unsigned XLEN              = 64,
    parameter int unsigned TRAP_DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic            ex_jump_taken,
    input  logic [XLEN-1:0] ex_jump_target,
    input  logic            ex_trap,
    input  logic [3:0]      ex_trap_cause,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mem_busy,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_commit,
    output logic [3:0]      trap_cause,
    output logic [XLEN-1:0] trap_epc
);

    typedef enum logic [1:0] {StRun, StRedirect, StTrapDrain, StTrapJump} state_e;

    localparam logic [3:0] DrainInit = 4'(TRAP_DRAIN_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [3:0]      trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic            load_use;

    // Hazard only counts when no higher-priority control event is resolving in exec.
    assign load_use = id_valid && ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd))) &&
                      !ex_trap && !ex_jump_taken && !ex_branch_taken;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        redirect_pc_d  = redirect_pc_q;
        trap_cause_d   = trap_cause_q;
        trap_epc_d     = trap_epc_q;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        redirect_valid = 1'b0;
        trap_commit    = 1'b0;

        unique case (state_q)
            StRun: begin
                // A busy memory freezes everything; no bubble is needed while frozen.
                if (mem_busy) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else if (load_use) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
                if (ex_trap) begin
                    trap_cause_d = ex_trap_cause;
                    trap_epc_d   = ex_pc;
                    cnt_d        = DrainInit;
                    state_d      = StTrapDrain;
                end else if (ex_jump_taken) begin
                    redirect_pc_d = ex_jump_target;
                    state_d       = StRedirect;
                end else if (ex_branch_taken) begin
                    redirect_pc_d = ex_branch_target;
                    state_d       = StRedirect;
                end
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                flush_id       = 1'b1;
                flush_ex       = 1'b1;
                state_d        = StRun;
            end
            StTrapDrain: begin
                stall_if = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
                if (!mem_busy) begin
                    if (cnt_q == 4'd0) begin
                        redirect_pc_d = {mtvec[XLEN-1:2], 2'b00};
                        state_d       = StTrapJump;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StTrapJump: begin
                redirect_valid = 1'b1;
                trap_commit    = 1'b1;
                flush_id       = 1'b1;
                flush_ex       = 1'b1;
                state_d        = StRun;
            end
            default: state_d = StRun;
        endcase

        // Controls read as idle for the whole reset window, whatever the inputs do.
        if (reset) begin
            stall_if       = 1'b0;
            stall_id       = 1'b0;
            stall_ex       = 1'b0;
            flush_id       = 1'b0;
            flush_ex       = 1'b0;
            redirect_valid = 1'b0;
            trap_commit    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            cnt_q         <= 4'd0;
            redirect_pc_q <= '0;
            trap_cause_q  <= 4'd0;
            trap_epc_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            trap_cause_q  <= trap_cause_d;
            trap_epc_q    <= trap_epc_d;
        end
    end

    assign redirect_pc = redirect_pc_q;
    assign trap_cause  = trap_cause_q;
    assign trap_epc    = trap_epc_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Each scenario task builds a per-cycle stimulus
// list and pushes the expected output vector for every cycle onto a scoreboard queue. It then
// replays the stimulus and pops/compares one expected vector per cycle.
module tb_pipe_hazard_ctrl;

    localparam int XLEN = 64;
    localparam int OW   = 7 + XLEN + 4 + XLEN;

    typedef struct packed {
        logic            rst;
        logic            id_valid;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            u1;
        logic            u2;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            bt;
        logic [XLEN-1:0] btgt;
        logic            jt;
        logic [XLEN-1:0] jtgt;
        logic            tr;
        logic [3:0]      cause;
        logic [XLEN-1:0] pc;
        logic            busy;
    } in_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_branch_taken, ex_jump_taken, ex_trap;
    logic [XLEN-1:0] ex_branch_target, ex_jump_target, ex_pc, mtvec;
    logic [3:0]      ex_trap_cause;
    logic            mem_busy;
    logic            stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic            redirect_valid, trap_commit;
    logic [XLEN-1:0] redirect_pc, trap_epc;
    logic [3:0]      trap_cause;

    int checks = 0;
    int fails  = 0;
    logic [OW-1:0] sb[$];

    // Model of the held registered outputs.
    logic [XLEN-1:0] exp_rpc   = '0;
    logic [3:0]      exp_cause = 4'd0;
    logic [XLEN-1:0] exp_epc   = '0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.XLEN(64), .TRAP_DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_jump_taken(ex_jump_taken), .ex_jump_target(ex_jump_target),
        .ex_trap(ex_trap), .ex_trap_cause(ex_trap_cause), .ex_pc(ex_pc),
        .mtvec(mtvec), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_commit(trap_commit), .trap_cause(trap_cause), .trap_epc(trap_epc)
    );

    function automatic in_t idle_in();
        in_t a;
        a = '0;
        return a;
    endfunction

    // Expected vector: control bits plus the currently modelled held values.
    function automatic logic [OW-1:0] mk(input logic si, sd, se, fi, fe, rv, tc);
        return {si, sd, se, fi, fe, rv, tc, exp_rpc, exp_cause, exp_epc};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect_valid, trap_commit,
                redirect_pc, trap_cause, trap_epc};
    endfunction

    task automatic apply(input in_t a);
        reset            = a.rst;
        id_valid         = a.id_valid;
        id_rs1           = a.rs1;
        id_rs2           = a.rs2;
        id_uses_rs1      = a.u1;
        id_uses_rs2      = a.u2;
        ex_rd            = a.rd;
        ex_reg_write     = a.rw;
        ex_mem_read      = a.mr;
        ex_branch_taken  = a.bt;
        ex_branch_target = a.btgt;
        ex_jump_taken    = a.jt;
        ex_jump_target   = a.jtgt;
        ex_trap          = a.tr;
        ex_trap_cause    = a.cause;
        ex_pc            = a.pc;
        mem_busy         = a.busy;
    endtask

    task automatic test_reset();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.rst = 1'b1; a.busy = 1'b1;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        a = idle_in();
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.id_valid = 1; a.rs1 = 5; a.u1 = 1; a.rd = 5; a.rw = 1; a.mr = 1;
        st.push_back(a); sb.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        a.rd = 0;                             // bubble now in exec
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        a.rs1 = 0;                            // x0 never hazards
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        a = idle_in(); a.id_valid = 1; a.rs2 = 7; a.u2 = 1; a.rd = 7; a.rw = 1; a.mr = 1;
        st.push_back(a); sb.push_back(mk(1, 1, 0, 0, 1, 0, 0));
        a.u2 = 0;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        a.u2 = 1; a.rw = 0;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        a.rw = 1; a.id_valid = 0;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL load_use step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.bt = 1; a.btgt = 64'h1000;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_rpc = 64'h1000;
        a.btgt = 64'h3000;                    // ignored while redirecting
        st.push_back(a); sb.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        a = idle_in();
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL branch step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.jt = 1; a.jtgt = 64'h2000; a.bt = 1; a.btgt = 64'h1000;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_rpc = 64'h2000;
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        // Trap beats jump, branch and a concurrent load-use hazard.
        a.tr = 1; a.cause = 4'd5; a.pc = 64'h44;
        a.id_valid = 1; a.rs1 = 3; a.u1 = 1; a.rd = 3; a.rw = 1; a.mr = 1;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_cause = 4'd5; exp_epc = 64'h44;
        st.push_back(idle_in()); sb.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        st.push_back(idle_in()); sb.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        exp_rpc = 64'h100;
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 1, 1, 1, 1));
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL priority step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap_busy();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.tr = 1; a.cause = 4'd2; a.pc = 64'h80;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_cause = 4'd2; exp_epc = 64'h80;
        a = idle_in(); a.busy = 1;
        for (int k = 0; k < 3; k++) begin
            st.push_back(a); sb.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        end
        for (int k = 0; k < 2; k++) begin
            st.push_back(idle_in()); sb.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        end
        exp_rpc = 64'h100;
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 1, 1, 1, 1));
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL trap_busy step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_branch();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        // Busy beats the load-use bubble.
        a = idle_in(); a.busy = 1; a.id_valid = 1; a.rs1 = 9; a.u1 = 1; a.rd = 9;
        a.rw = 1; a.mr = 1;
        st.push_back(a); sb.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        a = idle_in(); a.busy = 1; a.bt = 1; a.btgt = 64'h1800;
        st.push_back(a); sb.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        exp_rpc = 64'h1800;
        a = idle_in(); a.busy = 1;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        st.push_back(a); sb.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL busy_branch step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.bt = 1; a.btgt = 64'h10;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_rpc = 64'h10;
        // Taken branch and hazard during REDIRECT are both ignored.
        a.btgt = 64'h20; a.id_valid = 1; a.rs1 = 4; a.u1 = 1; a.rd = 4; a.rw = 1; a.mr = 1;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        a = idle_in(); a.jt = 1; a.jtgt = 64'h30;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_rpc = 64'h30;
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 1, 1, 1, 0));
        st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL back_to_back step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        in_t st[$];
        in_t a;
        logic [OW-1:0] got, e;
        a = idle_in(); a.tr = 1; a.cause = 4'd9; a.pc = 64'h200;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_cause = 4'd9; exp_epc = 64'h200;
        st.push_back(idle_in()); sb.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        exp_rpc = '0; exp_cause = 4'd0; exp_epc = '0;
        a = idle_in(); a.rst = 1;
        st.push_back(a); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            st.push_back(idle_in()); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end
        foreach (st[i]) begin
            apply(st[i]); #3;
            got = obs(); e = sb.pop_front(); checks++;
            if (got !== e) begin
                fails++;
                $display("FAIL reset_mid_drain step %0d: got %h want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        mtvec = 64'h103;
        apply(idle_in());
        reset = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_trap_busy();
        test_busy_branch();
        test_back_to_back();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
